// File: rtl/spi_master.sv
// Single-byte SPI master: MOSI sent LSB-first, MISO received MSB-first, all four CPOL/CPHA modes.
// Define SPI_MASTER_LOOPBACK_EN to add an internal loopback (CS held high, MOSI fed to the sampler).
module spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MODE,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS
);
  localparam int unsigned   DIV      = (CLK_DIV == 0) ? 1 : CLK_DIV;
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam int unsigned   BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d, bit_nxt;
  logic                trail_q, trail_d;
  logic                fin_q, fin_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                half_end, sample, lb_start;

  assign half_end = (cnt_q == DIV_LAST);
  assign bit_nxt  = bit_q + BW'(1);

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        lb_q <= 1'b0;
    else if (state_q == IDLE && start) lb_q <= loopback;
  end
  assign lb_start = loopback;
  assign sample   = lb_q ? mosi_q : MISO;
`else
  assign lb_start = 1'b0;
  assign sample   = MISO;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      trail_q    <= 1'b0;
      fin_q      <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      trail_q    <= trail_d;
      fin_q      <= fin_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    trail_d    = trail_q;
    fin_d      = fin_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = MODE[1];
        mosi_d = 1'b0;
        cs_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = LEAD;
          cpha_d     = MODE[0];
          tx_d       = tx_data;
          rx_shift_d = '0;
          cnt_d      = '0;
          bit_d      = '0;
          trail_d    = 1'b0;
          fin_d      = 1'b0;
          busy_d     = 1'b1;
          cs_d       = lb_start;
          mosi_d     = MODE[0] ? 1'b0 : tx_data[0];
        end
      end
      // LEAD's last cycle produces edge 1, so LEAD and SHIFT share the edge logic;
      // trail_q tells whether the next edge is a trailing one.
      LEAD, SHIFT: begin
        cnt_d = half_end ? '0 : cnt_q + 8'd1;
        if (half_end) begin
          if (fin_q) begin
            state_d = TRAIL;
          end else begin
            state_d = SHIFT;
            sclk_d  = ~sclk_q;
            trail_d = ~trail_q;
            if (!trail_q) begin
              if (cpha_q) mosi_d = tx_q[bit_q];
              else        rx_shift_d = {rx_shift_q[DATA_W-2:0], sample};
            end else begin
              if (cpha_q)                  rx_shift_d = {rx_shift_q[DATA_W-2:0], sample};
              else if (bit_q != BIT_LAST)  mosi_d = tx_q[bit_nxt];
              if (bit_q == BIT_LAST) fin_d = 1'b1;
              else                   bit_d = bit_nxt;
            end
          end
        end
      end
      TRAIL: begin
        cnt_d = half_end ? '0 : cnt_q + 8'd1;
        if (half_end) begin
          state_d   = IDLE;
          cs_d      = 1'b1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS      = cs_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two DUTs (CLK_DIV=2 and CLK_DIV=1) share host inputs; a
// behavioural SPI slave per DUT shifts a byte out on MISO and captures MOSI at the mode's sample edges.
module tb_spi_master;
  localparam int NI = 2;
  localparam int D0 = 2;
  localparam int D1 = 1;

  typedef struct {
    int         inst;
    logic [1:0] mode;
    logic [7:0] tx;
    logic [7:0] slv;
    logic       lb;
    int         acc;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] txd;
  logic       lbk;
  logic       start [NI];
  logic       busy [NI], done [NI], sclk [NI], mosi [NI], cs [NI], miso [NI];
  logic [7:0] rxd [NI];

  exp_t exq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.CLK_DIV(D0), .DATA_W(8)) u_div2 (
    .clk(clk), .reset(reset), .MODE(mode), .start(start[0]), .tx_data(txd),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lbk),
`endif
    .busy(busy[0]), .done(done[0]), .rx_data(rxd[0]), .sclk(sclk[0]),
    .MOSI(mosi[0]), .MISO(miso[0]), .CS(cs[0])
  );

  spi_master #(.CLK_DIV(D1), .DATA_W(8)) u_div1 (
    .clk(clk), .reset(reset), .MODE(mode), .start(start[1]), .tx_data(txd),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lbk),
`endif
    .busy(busy[1]), .done(done[1]), .rx_data(rxd[1]), .sclk(sclk[1]),
    .MOSI(mosi[1]), .MISO(miso[1]), .CS(cs[1])
  );

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: slave model + scoreboard compare ----------------
  logic       in_xfer [NI], psclk [NI], has [NI], bbad [NI];
  exp_t       cur [NI];
  int         edges [NI], nsamp [NI], kbit [NI], cslow [NI], hi_cnt [NI];
  logic [7:0] cap [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int dv;
      dv = (i == 0) ? D0 : D1;
      if (reset) begin
        chk($sformatf("reset_state[%0d]", i),
            32'({cs[i], busy[i], done[i], sclk[i], mosi[i], rxd[i]}), 32'h1000);
        in_xfer[i] = 1'b0;
        has[i]     = 1'b0;
        miso[i]    = 1'b0;
        hi_cnt[i]  = 0;
        if (i == 0) exq.delete();
      end else begin
        if (busy[i] && !in_xfer[i]) begin
          in_xfer[i] = 1'b1;
          has[i]     = (exq.size() > 0);
          if (has[i]) cur[i] = exq[0];
          chk($sformatf("start_accepted[%0d]", i), 32'(has[i] && (cur[i].inst == i)), 32'd1);
          if (has[i] && cur[i].gap >= 0)
            chk($sformatf("cs_high_gap[%0d]", i), 32'(hi_cnt[i]), 32'(cur[i].gap));
          edges[i] = 0; nsamp[i] = 0; kbit[i] = 0; cap[i] = 8'h00; bbad[i] = 1'b0;
          cslow[i] = cs[i] ? 0 : 1;
          miso[i]  = (has[i] && !cur[i].mode[0]) ? cur[i].slv[7] : 1'b0;
        end else if (in_xfer[i]) begin
          if (!cs[i]) cslow[i]++;
          if (!cs[i] && !busy[i]) bbad[i] = 1'b1;
          if (sclk[i] !== psclk[i]) begin
            edges[i]++;
            if (edges[i] % 2 == 1) begin
              if (!cur[i].mode[0]) begin
                if (nsamp[i] < 8) cap[i][nsamp[i]] = mosi[i];
                nsamp[i]++;
              end else if (kbit[i] < 8) miso[i] = cur[i].slv[7-kbit[i]];
            end else begin
              if (cur[i].mode[0]) begin
                if (nsamp[i] < 8) cap[i][nsamp[i]] = mosi[i];
                nsamp[i]++;
              end
              kbit[i]++;
              if (!cur[i].mode[0] && kbit[i] < 8) miso[i] = cur[i].slv[7-kbit[i]];
            end
          end
        end else if (cs[i]) begin
          hi_cnt[i]++;
        end

        if (done[i]) begin
          if (!in_xfer[i] || !has[i]) begin
            checks++; errors++;
            $display("FAIL done_pulse[%0d]: got unexpected done expected no done", i);
          end else begin
            void'(exq.pop_front());
            chk($sformatf("rx_data[%0d]", i), 32'(rxd[i]),
                32'(cur[i].lb ? bitrev(cur[i].tx) : cur[i].slv));
            chk($sformatf("mosi_stream[%0d]", i), 32'(cap[i]), 32'(cur[i].tx));
            chk($sformatf("sclk_edges[%0d]", i), 32'(edges[i]), 32'd16);
            chk($sformatf("cs_low_cycles[%0d]", i), 32'(cslow[i]), 32'(cur[i].lb ? 0 : 18 * dv));
            chk($sformatf("done_latency[%0d]", i), 32'(cyc - cur[i].acc), 32'(18 * dv));
            chk($sformatf("idle_levels[%0d]", i), 32'({cs[i], sclk[i], bbad[i]}),
                32'({1'b1, cur[i].mode[1], 1'b0}));
          end
          in_xfer[i] = 1'b0;
          has[i]     = 1'b0;
          miso[i]    = 1'b0;
          hi_cnt[i]  = cs[i] ? 1 : 0;
        end
      end
      psclk[i] = sclk[i];
    end
    if (end_req && !end_ack) begin
      chk("scoreboard_empty", 32'(exq.size()), 32'd0);
      end_ack = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy[0] || busy[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy[0] || busy[1]) begin
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 200 cycles");
      $fatal(1);
    end
  endtask

  task automatic push(input int i, input logic [7:0] s, input logic l, input int gap);
    exp_t e;
    e.inst = i; e.mode = mode; e.tx = txd; e.slv = s; e.lb = l; e.acc = cyc; e.gap = gap;
    exq.push_back(e);
  endtask

  task automatic issue(input int i, input logic [1:0] m, input logic [7:0] t,
                       input logic [7:0] s, input logic l);
    wait_idle();
    mode = m; txd = t; lbk = l; start[i] = 1'b1;
    @(posedge clk); #1;
    push(i, s, l, -1);
    start[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    int n;
    reset = 1'b1; mode = 2'b00; txd = 8'h00; lbk = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    issue(0, 2'b00, 8'hA5, 8'h3C, 1'b0);
    issue(1, 2'b11, 8'h01, 8'hFF, 1'b0);

    issue(0, 2'b00, 8'h96, 8'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    txd = 8'hFF; mode = 2'b11; start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;

    issue(0, 2'b00, 8'hC3, 8'($urandom), 1'b0);
    repeat (7 * D0) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    issue(0, 2'b01, 8'h6B, 8'($urandom), 1'b0);

    wait_idle();
    mode = 2'b00; txd = 8'h12; lbk = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    push(0, 8'($urandom), 1'b0, -1);
    txd = 8'h34;
    n = 0;
    @(negedge clk);
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done[0]) begin
      $display("FAIL b2b_done: got done=0 expected done=1 within 100 cycles");
      $fatal(1);
    end
    s = 8'($urandom);
    @(posedge clk); #1;
    push(0, s, 1'b0, 1);
    start[0] = 1'b0;

    for (int k = 0; k < 16; k++) begin
      issue(int'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      mode = 2'($urandom); txd = 8'($urandom);
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    issue(0, 2'b00, 8'h0F, 8'h00, 1'b1);
    issue(1, 2'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    wait_idle();
    lbk = 1'b0;
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    end_req = 1'b1;
    n = 0;
    while (!end_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!end_ack) begin
      $display("FAIL end_handshake: got end_ack=0 expected 1");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 20000 cycles");
    $fatal(1);
  end
endmodule
